// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock frequency monitor.
`timescale 1ns/1ps
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } mon_state_t;

  localparam int DEF_EXP_HALF = 50;
  localparam int DEF_TOL      = 2;
  localparam int DEF_TIMEOUT  = 4 * DEF_EXP_HALF;

endpackage

// File: rtl/clk_freq_monitor_sync_edge_det.sv
// Synchronizes an asynchronous clock into i_clk and flags both of its edges
// as a single-cycle pulse.
`timescale 1ns/1ps
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] ^ r_dly;

endmodule

// File: rtl/clk_freq_monitor.sv
// Half-period measurement, range/lock status and loss-of-clock detection for
// a slow asynchronous clock. Define CLK_FREQ_MONITOR_STATS_EN for min/max stats.
`timescale 1ns/1ps
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_HALF    = DEF_EXP_HALF,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_mon_clk,
  input  logic             i_enable,
`ifdef CLK_FREQ_MONITOR_STATS_EN
  input  logic             i_stats_clr,
  output logic [CNT_W-1:0] o_min_period,
  output logic [CNT_W-1:0] o_max_period,
`endif
  output logic [CNT_W-1:0] o_half_period,
  output logic             o_valid,
  output logic             o_in_range,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  EXP_C  = CNT_W'(EXP_HALF);
  localparam logic [CNT_W-1:0]  TOL_C  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_C = LOCK_W'(LOCK_CNT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TMO_C) ? TMO_C : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  mon_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_nxt;
  logic              w_edge;
  logic              w_meas;
  logic              w_tmo;
  logic              w_in_range;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_mon_clk),
    .o_edge  (w_edge)
  );

  assign w_in_range = (abs_diff(r_cnt, EXP_C) <= TOL_C);
  assign w_lock_nxt = (r_lock_cnt >= LOCK_C) ? LOCK_C : r_lock_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // An edge always wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_meas      = 1'b0;
    w_tmo       = 1'b0;
    if (!i_enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ARM;
        ARM: begin
          if (w_edge)              w_state_nxt = MEAS;
          else if (r_cnt == TMO_C) w_tmo = 1'b1;
        end
        MEAS: begin
          if (w_edge) begin
            w_meas = 1'b1;
          end else if (r_cnt == TMO_C) begin
            w_tmo       = 1'b1;
            w_state_nxt = ARM;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt         <= '0;
      r_lock_cnt    <= '0;
      o_half_period <= '0;
      o_valid       <= 1'b0;
      o_in_range    <= 1'b0;
      o_locked      <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      // Counter is parked at zero while idle so arming never starts timed out.
      if (r_state == IDLE) r_cnt <= '0;
      else if (w_edge)     r_cnt <= CNT_W'(1);
      else                 r_cnt <= sat_inc(r_cnt);

      o_valid <= w_meas;

      if (!i_enable) begin
        r_lock_cnt <= '0;
        o_in_range <= 1'b0;
        o_locked   <= 1'b0;
        o_timeout  <= 1'b0;
      end else if (w_meas) begin
        o_half_period <= r_cnt;
        o_in_range    <= w_in_range;
        if (w_in_range) begin
          r_lock_cnt <= w_lock_nxt;
          o_locked   <= (w_lock_nxt == LOCK_C);
        end else begin
          r_lock_cnt <= '0;
          o_locked   <= 1'b0;
        end
      end else if (w_tmo) begin
        o_timeout  <= 1'b1;
        o_locked   <= 1'b0;
        r_lock_cnt <= '0;
      end else if (w_edge) begin
        o_timeout <= 1'b0;
      end
    end
  end

`ifdef CLK_FREQ_MONITOR_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_min_period <= '1;
      o_max_period <= '0;
    end else if (i_stats_clr) begin
      o_min_period <= w_meas ? r_cnt : '1;
      o_max_period <= w_meas ? r_cnt : '0;
    end else if (w_meas) begin
      if (r_cnt < o_min_period) o_min_period <= r_cnt;
      if (r_cnt > o_max_period) o_max_period <= r_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench for clk_freq_monitor: a divider model issues edges from a
// directed table and queues the hand-computed measurement each edge must produce.
`timescale 1ns/1ps
module tb_clk_freq_monitor;

  localparam int CNT_W = 16;

  typedef struct {
    int gap;
    bit vld;
    int per;
    bit inr;
    bit lck;
  } edge_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mon = 1'b0;
  logic             en  = 1'b0;
  logic [CNT_W-1:0] o_half_period;
  logic             o_valid, o_in_range, o_locked, o_timeout;
`ifdef CLK_FREQ_MONITOR_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] o_min_period, o_max_period;
`endif

  edge_t  gen_q[$];
  edge_t  sb_q[$];
  int     since = 0;
  int     edge_cnt = 0;
  longint cyc = 0;
  longint last_edge_cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;

  clk_freq_monitor u_dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_mon_clk     (mon),
    .i_enable      (en),
`ifdef CLK_FREQ_MONITOR_STATS_EN
    .i_stats_clr   (stats_clr),
    .o_min_period  (o_min_period),
    .o_max_period  (o_max_period),
`endif
    .o_half_period (o_half_period),
    .o_valid       (o_valid),
    .o_in_range    (o_in_range),
    .o_locked      (o_locked),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int gap, input bit vld, input int per, input bit inr, input bit lck);
    edge_t e;
    e.gap = gap; e.vld = vld; e.per = per; e.inr = inr; e.lck = lck;
    gen_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (gen_q.size() != 0 && t < 3000) begin
      step(1);
      t++;
    end
    if (gen_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain: %0d edges still pending, expected 0", name, gen_q.size());
    end
  endtask

  // Divider model: one edge per table entry, gap cycles after the previous edge.
  initial begin
    edge_t e;
    forever begin
      @(negedge clk);
      cyc++;
      since++;
      if (gen_q.size() != 0 && since >= gen_q[0].gap) begin
        e = gen_q.pop_front();
        mon = ~mon;
        since = 0;
        edge_cnt++;
        last_edge_cyc = cyc;
        if (e.vld) sb_q.push_back(e);
      end
    end
  end

  // Monitor: every o_valid pulse must match the oldest queued measurement.
  initial begin
    edge_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: o_half_period=%0d, no measurement expected (t=%0t)",
                   o_half_period, $time);
        end else begin
          e = sb_q.pop_front();
          check("half_period", o_half_period, e.per);
          check("in_range", o_in_range, e.inr);
          check("locked", o_locked, e.lck);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;

    step(3);
    check("rst_half_period", o_half_period, 0);
    check("rst_valid", o_valid, 0);
    check("rst_in_range", o_in_range, 0);
    check("rst_locked", o_locked, 0);
    check("rst_timeout", o_timeout, 0);
`ifdef CLK_FREQ_MONITOR_STATS_EN
    check("rst_min", o_min_period, 16'hFFFF);
    check("rst_max", o_max_period, 0);
`endif
    rst = 1'b0;
    step(2);
    en = 1'b1;
    step(2);

    // Nominal 50: first edge only arms, lock on 4th valid.
    push(50, 0, 0, 0, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 1);
    push(50, 1, 50, 1, 1);
    push(50, 1, 50, 1, 1);
    wait_drain("nominal");
    step(10);

    // Out of range breaks lock; tolerance edges 52/48 keep it; 47 breaks it.
    push(53, 1, 53, 0, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 1);
    push(52, 1, 52, 1, 1);
    push(48, 1, 48, 1, 1);
    push(47, 1, 47, 0, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 1);
    wait_drain("range");
    step(10);
    check("locked_before_stop", o_locked, 1);

    // Loss of clock.
    t = 0;
    while (o_timeout !== 1'b1 && t < 400) begin
      step(1);
      t++;
    end
    n_chk++;
    if ((cyc - last_edge_cyc) < 200 || (cyc - last_edge_cyc) > 206) begin
      n_fail++;
      $display("FAIL timeout_delay: o_timeout after %0d cycles, expected 200..206", cyc - last_edge_cyc);
    end
    check("timeout_set", o_timeout, 1);
    check("timeout_locked", o_locked, 0);

    // Restart: first edge clears timeout without valid, second measures.
    base = edge_cnt;
    push(50, 0, 0, 0, 0);
    push(50, 1, 50, 1, 0);
    t = 0;
    while (edge_cnt == base && t < 500) begin
      step(1);
      t++;
    end
    step(6);
    check("timeout_clear", o_timeout, 0);
    wait_drain("restart");
    step(10);

    // Async reset mid-period with the monitored clock low.
    push(50, 1, 50, 1, 0);
    wait_drain("pre_reset");
    step(20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_half_period", o_half_period, 0);
    check("arst_in_range", o_in_range, 0);
    check("arst_locked", o_locked, 0);
    check("arst_valid", o_valid, 0);
    step(2);
    rst = 1'b0;
    push(50, 0, 0, 0, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 0);
    push(50, 1, 50, 1, 1);
    wait_drain("post_reset");
    step(10);
    check("locked_before_disable", o_locked, 1);

    // Disable while locked.
    en = 1'b0;
    step(1);
    check("dis_locked", o_locked, 0);
    check("dis_half_period", o_half_period, 50);
    push(50, 0, 0, 0, 0);
    push(50, 0, 0, 0, 0);
    push(50, 0, 0, 0, 0);
    wait_drain("disabled");
    step(5);
    check("dis_half_hold", o_half_period, 50);
    check("dis_in_range", o_in_range, 0);
    en = 1'b1;
    push(50, 0, 0, 0, 0);
    push(50, 1, 50, 1, 0);
    wait_drain("reenable");
    step(10);

`ifdef CLK_FREQ_MONITOR_STATS_EN
    check("stats_min_pre", o_min_period, 50);
    check("stats_max_pre", o_max_period, 50);
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    check("stats_clr_min", o_min_period, 16'hFFFF);
    check("stats_clr_max", o_max_period, 0);
`endif
    push(49, 1, 49, 1, 0);
    push(50, 1, 50, 1, 0);
    push(51, 1, 51, 1, 1);
    wait_drain("stats");
    step(10);
`ifdef CLK_FREQ_MONITOR_STATS_EN
    check("stats_min", o_min_period, 49);
    check("stats_max", o_max_period, 51);
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    check("stats_clr2_min", o_min_period, 16'hFFFF);
    check("stats_clr2_max", o_max_period, 0);
`endif

    step(20);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
